// File: rtl/pipo_load_arbiter.sv
// -----------------------------------------------------------------------------
// pipo_load_arbiter
//
// Shares one WIDTH-bit parallel-in/parallel-out holding register between NREQ
// requesters. A round-robin arbiter picks one requester, pulses its grant,
// captures its word into the register, and then presents the word downstream
// with valid/ack flow control. After every ack it inserts HOLD_CYCLES idle
// cycles before the next grant may be issued.
//
// Parameters
//   WIDTH       data word width in bits
//   NREQ        number of requesters (2..8)
//   HOLD_CYCLES idle cycles after each ack before the next grant (0..15)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   req        per-requester request, held until the matching gnt bit is seen
//   req_data   packed words, requester i on bits [i*WIDTH +: WIDTH]
//   gnt        one-hot, one-cycle grant pulse (combinational)
//   out        registered holding-register word
//   out_valid  out holds an unconsumed word
//   out_src    index of the requester whose word is in out
//   out_ack    consumer accepts out (ignored while out_valid = 0)
//   busy       high while a word is held or the post-ack gap is running
//
// Build option
//   PIPO_ARB_PRIO0_EN  when defined, requester 0 has strict priority and
//                      granting it does not move the round-robin pointer.
// -----------------------------------------------------------------------------
module pipo_load_arbiter #(
  parameter int WIDTH       = 4,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           gnt,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [$clog2(NREQ)-1:0]   out_src,
  input  logic                      out_ack,
  output logic                      busy
);

  localparam int SRC_W = $clog2(NREQ);
  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FULL = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q;
  logic [SRC_W-1:0]   ptr_q;
  logic [SRC_W-1:0]   ptr_d;
  logic [GAP_W-1:0]   gap_q;
  logic [WIDTH-1:0]   out_q;
  logic [SRC_W-1:0]   src_q;
  logic               valid_q;
  logic               busy_q;

  // ---------------------------------------------------------------------------
  // Unpack the requester words and build the "at or above pointer" mask.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] word [NREQ];
  logic [NREQ-1:0]  upper_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign word[gi]       = req_data[gi*WIDTH +: WIDTH];
      assign upper_mask[gi] = (SRC_W'(gi) >= ptr_q);
    end
  endgenerate

  // Index of the lowest set bit; callers only use it when v != 0.
  function automatic logic [SRC_W-1:0] lowest_idx(input logic [NREQ-1:0] v);
    lowest_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_idx = SRC_W'(i);
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Winner selection. The search starts at the pointer and wraps upward: the
  // lowest request at or above the pointer wins, otherwise the lowest request
  // overall (which then lies below the pointer).
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]  cand_upper;
  logic             win_found;
  logic [SRC_W-1:0] win_idx;
  logic [SRC_W-1:0] rr_idx;
  logic [SRC_W-1:0] rr_next;

  assign cand_upper = req & upper_mask;
  assign win_found  = |req;
  assign rr_idx     = (|cand_upper) ? lowest_idx(cand_upper) : lowest_idx(req);
  assign rr_next    = (rr_idx == SRC_W'(NREQ - 1)) ? '0 : rr_idx + 1'b1;

`ifdef PIPO_ARB_PRIO0_EN
  // Requester 0 overrides the rotation and leaves the pointer where it was,
  // so the remaining requesters keep their round-robin position.
  assign win_idx = req[0] ? '0    : rr_idx;
  assign ptr_d   = req[0] ? ptr_q : rr_next;
`else
  assign win_idx = rr_idx;
  assign ptr_d   = rr_next;
`endif

  // ---------------------------------------------------------------------------
  // Grant pulse. Masked during reset so a requester never sees a grant whose
  // data is not going to be captured.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt = '0;
    if ((state_q == ST_IDLE) && win_found && !reset) begin
      gnt[win_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE -> FULL on a grant, FULL -> GAP (or IDLE) on ack,
  // GAP -> IDLE when the gap counter has run down.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gap_q   <= '0;
      out_q   <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            out_q   <= word[win_idx];
            src_q   <= win_idx;
            ptr_q   <= ptr_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_FULL;
          end
        end

        ST_FULL: begin
          // out/out_src are left untouched so the word stays stable under
          // backpressure and keeps its last value after ack.
          if (out_ack) begin
            valid_q <= 1'b0;
            if (HOLD_CYCLES == 0) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              // Counter runs HOLD_CYCLES-1 .. 0, i.e. HOLD_CYCLES gap cycles.
              gap_q   <= GAP_W'(HOLD_CYCLES - 1);
              state_q <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (gap_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end

        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;

endmodule

// File: doc/pipo_load_arbiter.md
# pipo_load_arbiter

Round-robin arbiter and load sequencer that shares one WIDTH-bit parallel-in/parallel-out holding register between NREQ requesters. It picks one requester, pulses that requester's grant, captures its parallel word into the register, and presents the word downstream with valid/ack flow control. It then enforces a programmable gap before the next load. It sits between the requester datapaths and the single downstream consumer of the PIPO stage.

## Interface
- WIDTH, 4, data word width in bits.
- NREQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 2, idle cycles forced after each ack before the next grant (0..15).

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- req  input  NREQ  per-requester request; held high until the matching gnt bit is seen.
- req_data  input  NREQ*WIDTH  packed words; requester i drives bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant pulse, one cycle wide; combinational from state, pointer and req.
- out  output  WIDTH  registered PIPO word.
- out_valid  output  1  out holds an unconsumed word.
- out_src  output  clog2(NREQ)  index of the requester whose word is in out.
- out_ack  input  1  consumer accepts out; only meaningful while out_valid=1.
- busy  output  1  high in FULL or GAP.

## Operation
- State machine has three states: IDLE, FULL, GAP.
- IDLE:
  - If req != 0, gnt has exactly one bit set, for the winner.
  - On that edge: out <= winner's word, out_src <= winner index, pointer <= winner+1 (mod NREQ), state -> FULL.
  - If req == 0, gnt = 0 and the state stays IDLE.
- FULL:
  - out_valid = 1 and gnt = 0.
  - out_ack = 1 -> GAP, with the gap counter loaded to HOLD_CYCLES-1. If HOLD_CYCLES = 0, go straight to IDLE.
  - out_ack = 0 -> stay in FULL. out and out_src stay stable.
- GAP:
  - gnt = 0 and out_valid = 0.
  - The counter decrements each cycle; at 0 the state goes to IDLE.
- Round-robin: search starts at the pointer and wraps upward. The first set req bit wins.
- out keeps its last value after ack; only out_valid qualifies it.
- req bits that deassert before a grant are simply not considered; no error is raised.
- out_ack while out_valid = 0 is ignored.
- Reset values: state IDLE, pointer 0, gap counter 0, out 0, out_src 0, out_valid 0, busy 0, gnt 0.
- Reset mid-operation: a word held in FULL is discarded with no ack required. A grant asserted in the reset cycle does not capture data.

## Timing
- Grant-to-valid latency: gnt is high in cycle n, out_valid rises in cycle n+1.
- Ack in cycle m, with m being the cycle in FULL when out_ack is sampled high:
  - out_valid drops in m+1.
  - The earliest next gnt is in cycle m+1+HOLD_CYCLES.
- Maximum throughput is one word per (2 + HOLD_CYCLES) cycles with ack held high.
- A requester whose req is high in IDLE waits at most NREQ-1 other grants before its own (round-robin, macro off).
- The pointer updates only on a grant, never on reset-free idle cycles.

## Configuration
- PIPO_ARB_PRIO0_EN:
  - Defined: requester 0 has strict priority. Whenever req[0] = 1 in IDLE, it wins regardless of the pointer. Granting requester 0 does not move the pointer. Other requesters use round-robin among themselves.
  - Undefined: pure round-robin over all NREQ requesters, as described above.

## Test plan
- Reset: assert reset for 2 cycles while in FULL -> next cycle out_valid = 0, out = 0, out_src = 0, gnt = 0, busy = 0.
- Single load: req = 4'b0100, req_data word 2 = 4'hA, out_ack held 1 -> gnt = 4'b0100 in cycle n; out = 4'hA, out_src = 2, out_valid = 1 in n+1; out_valid = 0 in n+2; busy low in n+4 (HOLD_CYCLES = 2).
- Round-robin fairness: req = 4'b1111 held, ack immediate -> grant order is 0, 1, 2, 3, 0. Grant spacing is 4 cycles.
- Backpressure: load word 4'h5, out_ack = 0 for 10 cycles while req = 4'b0011 -> out stays 4'h5, gnt stays 0, out_valid stays 1; the first gnt comes 3 cycles after ack.
- HOLD_CYCLES = 0 with req = 4'b0001 held -> gnt pulses every 2 cycles with out_ack = 1.
- With PIPO_ARB_PRIO0_EN defined: req = 4'b1111 held -> every grant goes to requester 0. Dropping req[0] after 3 grants -> order becomes 1, 2, 3, 1.
